bin_to_bcd_seq: RTL and testbench
=================================

# bin_to_bcd_seq

Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter. It takes a 10-bit switch value and produces four registered BCD digits for the downstream seven-segment decoders. The conversion is iterative, one bit per clock, so the datapath needs only per-digit add-3 logic and no combinational cascade. It uses a start/busy/done handshake and holds its result stable between conversions so the display never shows intermediate values.

## Interface
- W_BIN, 10: binary input width; legal range 1..13.
- N_DIGITS, 4: number of BCD output digits.
  - Elaboration must fail unless 10^N_DIGITS > 2^W_BIN − 1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  request a conversion; sampled only in IDLE.
- bin  in  W_BIN  unsigned binary value; sampled on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse marking the first cycle in which bcd holds the new result.
- bcd  out  4*N_DIGITS  registered result; digit i occupies bits [4i+3:4i] (digit 0 = units).

## Operation
- Reset (asynchronous, rst_n low): state=IDLE, busy=0, done=0, bcd=0, all scratch registers and the bit counter cleared.
- States:
  - IDLE → SHIFT on an edge with start=1.
  - SHIFT → IDLE on the edge that performs the final shift.
  - No other transitions.
- Accept (IDLE, start=1): shift register ← bin, scratch BCD ← 0, counter ← W_BIN.
- Each SHIFT edge:
  - Every scratch digit ≥5 gets +3; the adjusted values feed the same edge.
  - {scratch, shift register} shifts left by 1.
  - counter decrements.
- Final shift (counter==1):
  - bcd ← shifted scratch value.
  - done ← 1 for the next cycle.
  - state ← IDLE.
- bcd changes only on the final-shift edge or on reset; it holds otherwise.
- start in SHIFT is ignored; bin changes during SHIFT have no effect.
- start may be high in the done cycle; it is accepted there (state is IDLE).
- Adjusted digit values never exceed 12 and post-shift digits never exceed 9, so no overflow flag is needed.

## Timing
- With accept at edge k:
  - busy is high from after edge k until after edge k+W_BIN.
  - done and the new bcd are visible after edge k+W_BIN.
  - done drops after edge k+W_BIN+1 unless that edge also completes a conversion, which is impossible.
- Latency is W_BIN clocks from accept to result (10 by default).
- Maximum throughput is one conversion per W_BIN+1 clocks when start is held high.
- busy and done are never high in the same cycle.
- Reset mid-conversion: the conversion aborts immediately, bcd=0, and no done pulse is produced.
- bin=0 still takes the full W_BIN cycles.

## Structure
- Shared package holds:
  - the state encoding (IDLE, SHIFT);
  - default W_BIN and N_DIGITS;
  - a counter-width constant, clog2(W_BIN+1).
- One sub-module, bcd_digit_adj: combinational, 4-bit in / 4-bit out, returns d+3 when d≥5 and d otherwise. Instantiate it N_DIGITS times in a generate loop.
- Top-level board wiring:
  - bin comes from the switches.
  - bcd digits 0..2 drive the existing seven-segment decoders.
  - start can be tied high for continuous refresh.

## Test plan
- bin=0, start pulse → done after 10 clocks, bcd=0x0000, busy high for exactly 10 cycles.
- bin=1023 → bcd=0x1023 with done; bin=59 → 0x0059; bin=999 → 0x0999 (exercises the digit-5 and digit-9 boundaries).
- start=1 held continuously, with bin stepped 0..1023 between accepts → every result matches the decimal value; accepts occur every 11 clocks; done never overlaps busy.
- Start at bin=512, then change bin to 7 and pulse start mid-conversion → result 0x0512 and only one done pulse.
- rst_n low at shift 5 of a conversion of bin=777, after a prior result 0x0123 → bcd=0 immediately, busy=0, no done pulse; a fresh conversion afterwards gives 0x0777.
- start asserted in the done cycle → the new conversion is accepted that edge; the previous bcd holds until the next done.

Source files
------------

// File: rtl/bin_to_bcd_seq_pkg.sv
// bin_to_bcd_seq_pkg: state encoding, default sizes and sizing helpers for the BCD converter
package bin_to_bcd_seq_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int W_BIN_DEF = 10;
  localparam int N_DIGITS_DEF = 4;
  localparam int CNT_W_DEF = $clog2(W_BIN_DEF + 1);
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction
endpackage

// File: rtl/bin_to_bcd_seq_adj.sv
// bcd_digit_adj: add-3 correction applied to one BCD digit ahead of each shift
module bcd_digit_adj (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble converter, one bit per clock, result held between conversions
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int W_BIN    = W_BIN_DEF,
  parameter int N_DIGITS = N_DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [W_BIN-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd
);
  localparam int CW = cnt_w(W_BIN);
  localparam int BW = 4 * N_DIGITS;
  if (W_BIN < 1 || W_BIN > 13) begin : g_bad_w
    $error("bin_to_bcd_seq: W_BIN must be in 1..13");
  end
  if (pow10(N_DIGITS) <= (longint'(1) << W_BIN) - 1) begin : g_bad_n
    $error("bin_to_bcd_seq: N_DIGITS too small for W_BIN");
  end
  state_t           state;
  logic [W_BIN-1:0] sr;
  logic [BW-1:0]    scr;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    scr_next;
  logic [CW-1:0]    cnt;
  for (genvar i = 0; i < N_DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (.d(scr[4*i +: 4]), .q(adj[4*i +: 4]));
  end
  // adjusted digits shift left, pulling in the next binary MSB
  assign scr_next = {adj[BW-2:0], sr[W_BIN-1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      bcd   <= '0;
      sr    <= '0;
      scr   <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state <= SHIFT;
          busy  <= 1'b1;
          sr    <= bin;
          scr   <= '0;
          cnt   <= CW'(W_BIN);
        end
      end else begin
        sr  <= sr << 1;
        scr <= scr_next;
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          bcd   <= scr_next;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed stimulus with a scoreboard queue checked by an independent monitor
module tb_bin_to_bcd_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  bin = '0;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [15:0] sb[$];
  logic [15:0] held = '0;

  bin_to_bcd_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) held = '0;
    else begin
      check("busy_done_overlap", {31'd0, busy & done}, 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done with bcd %h want no done", bcd);
        end else begin
          logic [15:0] e;
          e = sb.pop_front();
          check("result", {16'd0, bcd}, {16'd0, e});
          held = e;
        end
      end else check("hold", {16'd0, bcd}, {16'd0, held});
    end
  end

  task automatic wait_done(input int lim);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!done && i < lim);
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no done want done within %0d cycles", lim);
    end
  endtask

  task automatic pulse(input logic [9:0] v, input logic [15:0] e);
    bin = v;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  logic [9:0]  dv[6] = '{10'd1023, 10'd59, 10'd999, 10'd500, 10'd95, 10'd5};
  logic [15:0] de[6] = '{16'h1023, 16'h0059, 16'h0999, 16'h0500, 16'h0095, 16'h0005};

  initial begin
    int nb;
    int last;
    int nd;
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_bcd", {16'd0, bcd}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bin = 10'd0;
    start = 1'b1;
    sb.push_back(16'h0000);
    nb = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) nb++;
    end
    check("zero_busy_cycles", nb, 32'd10);
    check("zero_done_seen", {31'd0, done}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      pulse(dv[i], de[i]);
      wait_done(20);
    end
    // a start and a new bin mid-conversion must not disturb the running result
    pulse(10'd512, 16'h0512);
    repeat (3) @(negedge clk);
    bin = 10'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("mid_start_extra_done", nd, 32'd0);
    pulse(10'd123, 16'h0123);
    wait_done(20);
    pulse(10'd777, 16'h0777);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_bcd", {16'd0, bcd}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 32'd0);
    pulse(10'd777, 16'h0777);
    wait_done(20);
    // start in the done cycle is accepted while the old bcd stays on display
    pulse(10'd45, 16'h0045);
    wait_done(20);
    bin = 10'd300;
    start = 1'b1;
    sb.push_back(16'h0300);
    @(negedge clk);
    start = 1'b0;
    check("done_cycle_accept_busy", {31'd0, busy}, 32'd1);
    check("done_cycle_hold", {16'd0, bcd}, 32'h0045);
    wait_done(20);
    bin = 10'd0;
    start = 1'b1;
    sb.push_back(to_bcd(0));
    last = 0;
    for (int v = 1; v <= 1023; v++) begin
      wait_done(20);
      if (v > 1) check("throughput", cyc - last, 32'd11);
      last = cyc;
      bin = 10'(v);
      sb.push_back(to_bcd(v));
    end
    wait_done(20);
    check("throughput", cyc - last, 32'd11);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
